// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder result path.
// Holds the field layout of the 37-bit internal sum word, IEEE special
// encodings and the normalizer/packer state encoding.
package fp_pkg;

  localparam int SIGN_BIT   = 36;
  localparam int EXP_MSB    = 35;
  localparam int EXP_LSB    = 28;
  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int GRS_W      = 3;
  localparam int MAG_W      = 28;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [22:0] QNAN_FRAC = 23'h400000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the 28-bit magnitude {carry, hidden, frac, G, R, S}.
// Ports:
//   i_data  [27:0]  magnitude to scan
//   o_count [4:0]   number of leading zeros (28 when i_data is zero)
module fp_lzc (
  input  logic [27:0] i_data,
  output logic [4:0]  o_count
);

  // Scanning upward lets the highest set bit overwrite earlier hits.
  always_comb begin
    o_count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_data[i]) o_count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Result-side normalizer / round-to-nearest-even / IEEE-754 single packer.
// Build option: FP_PACK_FAST_LZC_EN selects a one-cycle LZC + barrel-shift
// normalizer; otherwise normalization shifts one bit per cycle.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input handshake; ready only while idle
//   in_data  [36:0]       {sign, exp[7:0], carry, hidden, frac[22:0], G, R, S}
//   out_valid/out_ready   output handshake; result held until accepted
//   out_data [31:0]       packed IEEE single
//   out_ovf               result overflowed to infinity
//   out_inexact           any of G/R/S set after normalization
module fp_norm_pack
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [36:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_inexact
);

  state_t      r_state;
  logic        r_sign;
  logic [8:0]  r_exp;   // one spare bit so carry renormalization past 0xFE is visible
  logic [27:0] r_mag;
  logic [31:0] r_out_data;
  logic        r_out_ovf;
  logic        r_out_inexact;

  logic [27:0] w_norm_mag;
  logic [8:0]  w_norm_exp;
  logic        w_norm_done;
  logic [32:0] w_round;
  logic [7:0]  w_in_exp;

  assign w_in_exp = in_data[EXP_MSB:EXP_LSB];

  // Returns {ovf, packed word}. A result whose hidden bit is still clear is
  // subnormal (or zero) and packs with exponent 0.
  function automatic logic [32:0] round_pack(input logic s, input logic [8:0] e,
                                             input logic [27:0] m);
    logic        up;
    logic [24:0] sum;
    logic [8:0]  er;
    logic [22:0] fr;
    logic        hid;
    up  = m[2] & (m[1] | m[0] | m[3]);
    sum = {1'b0, m[26:3]} + {24'd0, up};
    if (sum[24]) begin
      er  = e + 9'd1;
      fr  = sum[23:1];
      hid = 1'b1;
    end else begin
      er  = e;
      fr  = sum[22:0];
      hid = sum[23];
    end
    if (!hid) er = 9'd0;
    if (er >= 9'h0FF) round_pack = {1'b1, s, EXP_MAX, 23'd0};
    else              round_pack = {1'b0, s, er[7:0], fr};
  endfunction

  assign w_round = round_pack(r_sign, r_exp, r_mag);

`ifdef FP_PACK_FAST_LZC_EN
  logic [4:0] w_lz;
  logic [8:0] w_sh_want;
  logic [8:0] w_room;
  logic [8:0] w_sh;

  fp_lzc u_lzc (
    .i_data  (r_mag),
    .o_count (w_lz)
  );

  // Left shift brings the leading one to the hidden position (lz == 1), but
  // never pushes the exponent below 1; the remainder stays subnormal.
  assign w_sh_want = {4'd0, w_lz} - 9'd1;
  assign w_room    = r_exp - 9'd1;
  assign w_sh      = (w_sh_want < w_room) ? w_sh_want : w_room;

  always_comb begin
    w_norm_mag  = r_mag;
    w_norm_exp  = r_exp;
    w_norm_done = 1'b1;
    if (r_mag == 28'd0) begin
      w_norm_exp = 9'd0;
    end else if (r_mag[CARRY_BIT]) begin
      w_norm_mag = {1'b0, r_mag[27:2], r_mag[1] | r_mag[0]};
      w_norm_exp = r_exp + 9'd1;
    end else begin
      w_norm_mag = r_mag << w_sh;
      w_norm_exp = r_exp - w_sh;
    end
  end
`else
  always_comb begin
    w_norm_mag  = r_mag;
    w_norm_exp  = r_exp;
    w_norm_done = 1'b0;
    if (r_mag == 28'd0) begin
      w_norm_exp  = 9'd0;
      w_norm_done = 1'b1;
    end else if (r_mag[CARRY_BIT]) begin
      // Bit shifted out is folded into sticky.
      w_norm_mag = {1'b0, r_mag[27:2], r_mag[1] | r_mag[0]};
      w_norm_exp = r_exp + 9'd1;
    end else if (!r_mag[HIDDEN_BIT] && (r_exp > 9'd1)) begin
      w_norm_mag = r_mag << 1;
      w_norm_exp = r_exp - 9'd1;
    end else begin
      w_norm_done = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_out_data    <= 32'd0;
      r_out_ovf     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_in_exp == EXP_MAX) begin
              r_state       <= DONE;
              r_out_data    <= {in_data[SIGN_BIT], EXP_MAX,
                                (|in_data[25:0]) ? QNAN_FRAC : 23'd0};
              r_out_ovf     <= 1'b0;
              r_out_inexact <= 1'b0;
            end else begin
              r_state <= NORM;
            end
          end
        end
        NORM: if (w_norm_done) r_state <= ROUND;
        ROUND: begin
          r_state       <= DONE;
          r_out_ovf     <= w_round[32];
          r_out_data    <= w_round[31:0];
          r_out_inexact <= |r_mag[GRS_W-1:0];
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Working datapath registers carry no reset; control qualifies their use.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_sign <= in_data[SIGN_BIT];
      r_exp  <= (w_in_exp == 8'd0) ? 9'd1 : {1'b0, w_in_exp};
      r_mag  <= in_data[27:0];
    end else if (r_state == NORM) begin
      r_mag <= w_norm_mag;
      r_exp <= w_norm_exp;
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign out_data    = r_out_data;
  assign out_ovf     = r_out_ovf;
  assign out_inexact = r_out_inexact;

endmodule
